exalu_block_sequencer: RTL and testbench

- Responder to the decode stage's extension controls. It executes one AES-128 extension instruction: `cmd_count` 128-bit words are read from `[cmd_src]`, passed through the cipher core, and written back to `[cmd_dst]`.
- It sits between the decoder/execute stage, the data-memory port and the AES core.
- It drives `busy`, which execute uses to hold the PC write-enable low.

---
 rtl/exalu_block_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_exalu_block_sequencer.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exalu_block_sequencer.sv
// AES-128 extension block sequencer.
// Runs one extension command: cmd_count 128-bit blocks are read from cmd_src
// one 32-bit word at a time. Each block goes through the cipher core, and the
// result is written back to cmd_dst. busy holds the PC write-enable low while
// a command runs.
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   cmd_valid/cmd_ready              command handshake from the decode stage
//   cmd_sel/cmd_src/cmd_dst/cmd_count  operation, byte addresses, block count
//   busy, done                       command in progress, completion pulse
//   mem_*                            data-memory port (ack = accepted, rdata same cycle)
//   core_in_*/core_mode              block handshake towards the cipher core
//   core_out_*                       result handshake from the cipher core
module exalu_block_sequencer #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CNT_W  = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_sel,
    input  logic [ADDR_W-1:0] cmd_src,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [CNT_W-1:0]  cmd_count,
    output logic              busy,
    output logic              done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_byteena,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              core_in_valid,
    input  logic              core_in_ready,
    output logic [127:0]      core_in_data,
    output logic              core_mode,
    input  logic              core_out_valid,
    output logic              core_out_ready,
    input  logic [127:0]      core_out_data
);
    localparam int unsigned CMP_W = CNT_W + 1;

    typedef enum logic [2:0] {S_IDLE, S_RD, S_SEND, S_WAIT, S_WR, S_DONE} state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   src_ptr_q, dst_ptr_q;
    logic [CNT_W-1:0]    count_q, blk_cnt_q;
    logic [1:0]          w_q;
    logic [127:0]        buf_q;
    logic                cmd_ready_q, busy_q, done_q;
    logic                mem_req_q, mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [31:0]         mem_wdata_q;
    logic [3:0]          mem_byteena_q;
    logic                core_in_valid_q, core_out_ready_q, core_mode_q;

    // Precomputed increments for the current pointers and counters.
    logic [ADDR_W-1:0]   src_ptr_d, dst_ptr_d;
    logic [1:0]          w_d;
    logic [CNT_W-1:0]    blk_cnt_d;
    logic                last_blk_c;
    logic                cmd_is_op_c;

    assign src_ptr_d   = src_ptr_q + ADDR_W'(4);
    assign dst_ptr_d   = dst_ptr_q + ADDR_W'(4);
    assign w_d         = w_q + 2'd1;
    assign blk_cnt_d   = blk_cnt_q + CNT_W'(1);
    // One extra bit so an all-ones count still terminates.
    assign last_blk_c  = (CMP_W'(blk_cnt_q) + CMP_W'(1)) == CMP_W'(count_q);
    assign cmd_is_op_c = (cmd_sel == 3'd1) || (cmd_sel == 3'd2);

    // Sequencer state, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= S_IDLE;
            src_ptr_q        <= '0;
            dst_ptr_q        <= '0;
            count_q          <= '0;
            blk_cnt_q        <= '0;
            w_q              <= '0;
            buf_q            <= '0;
            cmd_ready_q      <= 1'b1;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            mem_req_q        <= 1'b0;
            mem_we_q         <= 1'b0;
            mem_addr_q       <= '0;
            mem_wdata_q      <= '0;
            mem_byteena_q    <= '0;
            core_in_valid_q  <= 1'b0;
            core_out_ready_q <= 1'b0;
            core_mode_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        src_ptr_q   <= cmd_src;
                        dst_ptr_q   <= cmd_dst;
                        count_q     <= cmd_count;
                        blk_cnt_q   <= '0;
                        w_q         <= '0;
                        core_mode_q <= (cmd_sel == 3'd2);
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (!cmd_is_op_c || (cmd_count == '0)) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q       <= S_RD;
                            mem_req_q     <= 1'b1;
                            mem_we_q      <= 1'b0;
                            mem_byteena_q <= 4'b0000;
                            mem_addr_q    <= cmd_src;
                        end
                    end
                end
                S_RD: begin
                    if (mem_ack) begin
                        buf_q[{w_q, 5'd0} +: 32] <= mem_rdata;
                        src_ptr_q  <= src_ptr_d;
                        mem_addr_q <= src_ptr_d;
                        w_q        <= w_d;
                        if (w_q == 2'd3) begin
                            state_q         <= S_SEND;
                            mem_req_q       <= 1'b0;
                            core_in_valid_q <= 1'b1;
                        end
                    end
                end
                S_SEND: begin
                    if (core_in_ready) begin
                        state_q          <= S_WAIT;
                        core_in_valid_q  <= 1'b0;
                        core_out_ready_q <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (core_out_valid) begin
                        state_q          <= S_WR;
                        buf_q            <= core_out_data;
                        core_out_ready_q <= 1'b0;
                        mem_req_q        <= 1'b1;
                        mem_we_q         <= 1'b1;
                        mem_byteena_q    <= 4'b1111;
                        mem_addr_q       <= dst_ptr_q;
                        mem_wdata_q      <= core_out_data[31:0];
                    end
                end
                S_WR: begin
                    if (mem_ack) begin
                        dst_ptr_q   <= dst_ptr_d;
                        mem_addr_q  <= dst_ptr_d;
                        w_q         <= w_d;
                        mem_wdata_q <= buf_q[{w_d, 5'd0} +: 32];
                        if (w_q == 2'd3) begin
                            blk_cnt_q     <= blk_cnt_d;
                            mem_we_q      <= 1'b0;
                            mem_byteena_q <= 4'b0000;
                            mem_wdata_q   <= '0;
                            if (last_blk_c) begin
                                state_q   <= S_DONE;
                                mem_req_q <= 1'b0;
                                done_q    <= 1'b1;
                            end else begin
                                // Next block: keep the request up, switch to reading.
                                state_q    <= S_RD;
                                mem_addr_q <= src_ptr_q;
                            end
                        end
                    end
                end
                S_DONE: begin
                    state_q     <= S_IDLE;
                    busy_q      <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    core_mode_q <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready      = cmd_ready_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign mem_req        = mem_req_q;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign mem_byteena    = mem_byteena_q;
    assign core_in_valid  = core_in_valid_q;
    assign core_in_data   = buf_q;
    assign core_mode      = core_mode_q;
    assign core_out_ready = core_out_ready_q;

endmodule

// File: tb/tb_exalu_block_sequencer.sv
// Self-checking bench for exalu_block_sequencer: memory and cipher-core models
// with configurable stalls, scoreboarded memory/core transactions, and
// per-scenario checks of timing, handshakes and results.
module tb_exalu_block_sequencer;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_sel;
    logic [31:0]  cmd_src, cmd_dst;
    logic [11:0]  cmd_count;
    logic         busy, done;
    logic         mem_req, mem_we, mem_ack;
    logic [31:0]  mem_addr, mem_wdata, mem_rdata;
    logic [3:0]   mem_byteena;
    logic         core_in_valid, core_in_ready, core_mode;
    logic [127:0] core_in_data, core_out_data;
    logic         core_out_valid, core_out_ready;

    exalu_block_sequencer #(.ADDR_W(32), .CNT_W(12)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_count(cmd_count),
        .busy(busy), .done(done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_byteena(mem_byteena),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .core_in_valid(core_in_valid), .core_in_ready(core_in_ready),
        .core_in_data(core_in_data), .core_mode(core_mode),
        .core_out_valid(core_out_valid), .core_out_ready(core_out_ready),
        .core_out_data(core_out_data)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    txn_t         exp_mem[$];
    logic [128:0] exp_core[$];

    // Memory: 1024 words indexed by addr[11:2]; ref_mem is the bench's own copy.
    logic [31:0] mem     [1024];
    logic [31:0] ref_mem [1024];

    int mem_dly = 0, in_dly = 0, out_dly = 0;
    int mem_wait, in_wait, out_wait;
    logic         have_res;
    logic [127:0] res;

    assign mem_rdata      = mem[mem_addr[11:2]];
    assign mem_ack        = mem_req && (mem_wait >= mem_dly);
    assign core_in_ready  = core_in_valid && !have_res && (in_wait >= in_dly);
    assign core_out_valid = have_res && (out_wait >= out_dly);
    assign core_out_data  = res;

    // Stall counters and the echo core (result = ~input).
    always @(posedge clk) begin
        if (!rst_n) begin
            mem_wait <= 0; in_wait <= 0; out_wait <= 0;
            have_res <= 1'b0; res <= '0;
        end else begin
            mem_wait <= (mem_req && !mem_ack) ? mem_wait + 1 : 0;
            in_wait  <= (core_in_valid && !core_in_ready) ? in_wait + 1 : 0;
            if (core_in_valid && core_in_ready) begin
                res <= ~core_in_data; have_res <= 1'b1; out_wait <= 0;
            end else if (core_out_valid && core_out_ready) begin
                have_res <= 1'b0;
            end else if (have_res) begin
                out_wait <= out_wait + 1;
            end
        end
    end

    // Monitor: scoreboard pops, memory writes, stability while stalled.
    logic         prev_mem_pend = 1'b0, prev_core_pend = 1'b0;
    logic [68:0]  prev_mem;
    logic [127:0] prev_core;
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_req && prev_mem_pend) begin
                tests_run++;
                if ({mem_we, mem_addr, mem_wdata, mem_byteena} !== prev_mem) begin
                    tests_failed++;
                    $display("FAIL mem_stable: got %h required %h", {mem_we, mem_addr, mem_wdata, mem_byteena}, prev_mem);
                end
            end
            prev_mem_pend = mem_req && !mem_ack;
            prev_mem      = {mem_we, mem_addr, mem_wdata, mem_byteena};
            if (mem_req && mem_ack) begin
                txn_t t;
                tests_run++;
                if (exp_mem.size() == 0) begin
                    tests_failed++;
                    $display("FAIL mem_txn: unexpected we=%b addr=%h", mem_we, mem_addr);
                end else begin
                    t = exp_mem.pop_front();
                    if (mem_we !== t.we || mem_addr !== t.addr ||
                        (t.we && mem_wdata !== t.data) ||
                        mem_byteena !== (t.we ? 4'hF : 4'h0)) begin
                        tests_failed++;
                        $display("FAIL mem_txn: got we=%b addr=%h wdata=%h be=%b required we=%b addr=%h wdata=%h",
                                 mem_we, mem_addr, mem_wdata, mem_byteena, t.we, t.addr, t.data);
                    end
                end
                if (mem_we) mem[mem_addr[11:2]] = mem_wdata;
            end
            if (core_in_valid && prev_core_pend) begin
                tests_run++;
                if (core_in_data !== prev_core) begin
                    tests_failed++;
                    $display("FAIL core_in_stable: got %h required %h", core_in_data, prev_core);
                end
            end
            prev_core_pend = core_in_valid && !core_in_ready;
            prev_core      = core_in_data;
            if (core_in_valid && core_in_ready) begin
                logic [128:0] e;
                tests_run++;
                if (exp_core.size() == 0) begin
                    tests_failed++;
                    $display("FAIL core_in: unexpected block %h", core_in_data);
                end else begin
                    e = exp_core.pop_front();
                    if ({core_mode, core_in_data} !== e) begin
                        tests_failed++;
                        $display("FAIL core_in: got mode=%b data=%h required mode=%b data=%h",
                                 core_mode, core_in_data, e[128], e[127:0]);
                    end
                end
            end
        end else begin
            prev_mem_pend  = 1'b0;
            prev_core_pend = 1'b0;
        end
    end

    // Expected traffic for one block: 4 reads, one core block, 4 inverted writes.
    task automatic push_block(input logic mode, input logic [31:0] src, input logic [31:0] dst);
        logic [31:0]  a;
        logic [127:0] blk;
        for (int i = 0; i < 4; i++) begin
            a = src + 32'(4 * i);
            blk[32*i +: 32] = ref_mem[a[11:2]];
            exp_mem.push_back('{we: 1'b0, addr: a, data: ref_mem[a[11:2]]});
        end
        exp_core.push_back({mode, blk});
        for (int i = 0; i < 4; i++) begin
            a = dst + 32'(4 * i);
            ref_mem[a[11:2]] = ~blk[32*i +: 32];
            exp_mem.push_back('{we: 1'b1, addr: a, data: ~blk[32*i +: 32]});
        end
    endtask

    task automatic issue_cmd(input logic [2:0] sel, input logic [31:0] src,
                             input logic [31:0] dst, input logic [11:0] cnt);
        @(negedge clk);
        cmd_sel = sel; cmd_src = src; cmd_dst = dst; cmd_count = cnt; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // Cycles from acceptance until done is seen (-1 on timeout).
    task automatic wait_done(input int budget, output int cycles, output bit busy_ok);
        bit hit = 1'b0;
        cycles  = 0;
        busy_ok = 1'b1;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            cycles++;
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (done === 1'b1) hit = 1'b1;
        end
        if (!hit) cycles = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid = 1'b0;
        cmd_sel = '0; cmd_src = '0; cmd_dst = '0; cmd_count = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({cmd_ready, busy, done, mem_req, mem_we, mem_byteena, core_in_valid, core_out_ready, core_mode} !== 12'b1000_0000_0000 ||
            mem_addr !== '0 || mem_wdata !== '0 || core_in_data !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: ready=%b busy=%b done=%b req=%b addr=%h required ready=1 others 0",
                     cmd_ready, busy, done, mem_req, mem_addr);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_encrypt_single();
        int cyc; bit bok;
        push_block(1'b0, 32'h100, 32'h200);
        issue_cmd(3'd1, 32'h100, 32'h200, 12'd1);
        wait_done(100, cyc, bok);
        tests_run++;
        if (cyc !== 11) begin
            tests_failed++; $display("FAIL enc_latency: got %0d required 11", cyc);
        end
        tests_run++;
        if (!bok) begin
            tests_failed++; $display("FAIL enc_busy: got busy low required high");
        end
        tests_run++;
        if ({mem[128], mem[129], mem[130], mem[131]} !== {32'hFCFDFEFF, 32'hF8F9FAFB, 32'hF4F5F6F7, 32'hF0F1F2F3}) begin
            tests_failed++;
            $display("FAIL enc_result: got %h %h %h %h required fcfdfeff f8f9fafb f4f5f6f7 f0f1f2f3",
                     mem[128], mem[129], mem[130], mem[131]);
        end
    endtask

    task automatic test_decrypt_inplace();
        int cyc; bit bok;
        for (int b = 0; b < 3; b++) push_block(1'b1, 32'h400 + 32'(16 * b), 32'h400 + 32'(16 * b));
        issue_cmd(3'd2, 32'h400, 32'h400, 12'd3);
        wait_done(200, cyc, bok);
        tests_run++;
        if (cyc !== 31) begin
            tests_failed++; $display("FAIL dec_latency: got %0d required 31", cyc);
        end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0 || cmd_ready !== 1'b1) begin
            tests_failed++; $display("FAIL dec_single_done: got done=%b ready=%b required 0 1", done, cmd_ready);
        end
        tests_run++;
        if (mem[267] !== ref_mem[267] || mem[256] !== ref_mem[256]) begin
            tests_failed++; $display("FAIL dec_inplace: got %h %h required %h %h", mem[256], mem[267], ref_mem[256], ref_mem[267]);
        end
    endtask

    task automatic test_noop();
        int cyc; bit bok;
        logic [2:0]  sels[2] = '{3'd0, 3'd1};
        logic [11:0] cnts[2] = '{12'd5, 12'd0};
        for (int k = 0; k < 2; k++) begin
            issue_cmd(sels[k], 32'h100, 32'h300, cnts[k]);
            wait_done(10, cyc, bok);
            tests_run++;
            if (cyc !== 1 || mem_req !== 1'b0 || core_in_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL noop_%0d: got cycles=%0d req=%b civ=%b required 1 0 0", k, cyc, mem_req, core_in_valid);
            end
            @(negedge clk);
            tests_run++;
            if (busy !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0) begin
                tests_failed++; $display("FAIL noop_idle_%0d: got busy=%b ready=%b done=%b required 0 1 0", k, busy, cmd_ready, done);
            end
        end
    endtask

    task automatic test_stalls();
        int cyc; bit bok;
        for (int b = 0; b < 2; b++) push_block(1'b0, 32'h300 + 32'(16 * b), 32'h500 + 32'(16 * b));
        issue_cmd(3'd1, 32'h300, 32'h500, 12'd2);
        wait_done(200, cyc, bok);
        mem_dly = 3; in_dly = 5; out_dly = 7;
        for (int b = 0; b < 2; b++) push_block(1'b0, 32'h300 + 32'(16 * b), 32'h600 + 32'(16 * b));
        issue_cmd(3'd1, 32'h300, 32'h600, 12'd2);
        wait_done(500, cyc, bok);
        mem_dly = 0; in_dly = 0; out_dly = 0;
        tests_run++;
        if (cyc < 0 || !bok) begin
            tests_failed++; $display("FAIL stall_done: got cycles=%0d busy_ok=%b required done with busy", cyc, bok);
        end
        for (int i = 0; i < 8; i++) begin
            tests_run++;
            if (mem[384 + i] !== mem[320 + i]) begin
                tests_failed++; $display("FAIL stall_result_%0d: got %h required %h", i, mem[384 + i], mem[320 + i]);
            end
        end
    endtask

    task automatic test_wrap();
        int cyc; bit bok;
        push_block(1'b0, 32'hFFFF_FFF8, 32'h700);
        issue_cmd(3'd1, 32'hFFFF_FFF8, 32'h700, 12'd1);
        wait_done(100, cyc, bok);
        tests_run++;
        if (cyc !== 11) begin
            tests_failed++; $display("FAIL wrap_latency: got %0d required 11", cyc);
        end
    endtask

    task automatic test_cmd_blocking();
        int cyc; bit bok;
        push_block(1'b0, 32'h100, 32'h800);
        @(negedge clk);
        cmd_sel = 3'd1; cmd_src = 32'h100; cmd_dst = 32'h800; cmd_count = 12'd1; cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        push_block(1'b1, 32'h900, 32'hA00);
        cmd_sel = 3'd2; cmd_src = 32'h900; cmd_dst = 32'hA00;
        wait_done(100, cyc, bok);
        tests_run++;
        if (cyc !== 11) begin
            tests_failed++; $display("FAIL block_first_latency: got %0d required 11", cyc);
        end
        @(negedge clk);
        tests_run++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            tests_failed++; $display("FAIL block_idle: got ready=%b busy=%b required 1 0", cmd_ready, busy);
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b1 || mem_addr !== 32'h900 || mem_req !== 1'b1) begin
            tests_failed++; $display("FAIL block_second_accept: got busy=%b req=%b addr=%h required 1 1 00000900", busy, mem_req, mem_addr);
        end
        wait_done(100, cyc, bok);
        tests_run++;
        if (cyc !== 10) begin
            tests_failed++; $display("FAIL block_second_latency: got %0d required 10", cyc);
        end
    endtask

    task automatic test_reset_midflight();
        bit hit = 1'b0;
        bit req_seen = 1'b0;
        mem_dly = 3;
        push_block(1'b0, 32'h100, 32'hB00);
        issue_cmd(3'd1, 32'h100, 32'hB00, 12'd1);
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            if (mem_req && mem_we && mem_addr == 32'hB04) hit = 1'b1;
        end
        tests_run++;
        if (!hit) begin
            tests_failed++; $display("FAIL rst_mid_reach: got no second write required one");
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tests_run++;
        if ({cmd_ready, busy, done, mem_req, mem_we, mem_byteena, core_in_valid, core_out_ready, core_mode} !== 12'b1000_0000_0000 ||
            mem_addr !== '0 || mem_wdata !== '0 || core_in_data !== '0) begin
            tests_failed++;
            $display("FAIL rst_mid_state: ready=%b busy=%b req=%b we=%b addr=%h required ready=1 others 0",
                     cmd_ready, busy, mem_req, mem_we, mem_addr);
        end
        tests_run++;
        if (exp_mem.size() != 3) begin
            tests_failed++; $display("FAIL rst_mid_outstanding: got %0d required 3", exp_mem.size());
        end
        exp_mem.delete();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_req) req_seen = 1'b1;
        end
        tests_run++;
        if (req_seen) begin
            tests_failed++; $display("FAIL rst_mid_quiet: got mem_req after reset required none");
        end
        mem_dly = 0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h9E37_79B9 * 32'(i) ^ 32'h5A5A_0000;
        mem[64] = 32'h0302_0100; mem[65] = 32'h0706_0504;
        mem[66] = 32'h0B0A_0908; mem[67] = 32'h0F0E_0D0C;
        for (int i = 0; i < 1024; i++) ref_mem[i] = mem[i];

        test_reset();
        test_encrypt_single();
        test_decrypt_inplace();
        test_noop();
        test_stalls();
        test_wrap();
        test_cmd_blocking();
        test_reset_midflight();

        tests_run++;
        if (exp_mem.size() != 0 || exp_core.size() != 0) begin
            tests_failed++;
            $display("FAIL leftover_expected: got mem=%0d core=%0d required 0 0", exp_mem.size(), exp_core.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
